// File: rtl/instruction_loader.sv
// instruction_loader: assembles big-endian UART bytes into 32-bit words and
// writes them to the fetch-stage instruction memory until a HALT word is seen
// or the memory is full.
module instruction_loader #(
  parameter int unsigned     NB        = 32,
  parameter int unsigned     NB_BYTE   = 8,
  parameter int unsigned     TAM_I     = 256,
  parameter logic [NB-1:0]   HALT_WORD = 32'hFFFFFFFF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_instruction_write_enable,
  output logic [NB-1:0]      o_instruction_address,
  output logic [NB-1:0]      o_instruction_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow,
  output logic [NB-1:0]      o_word_count
);

  localparam int unsigned   BPW       = NB / NB_BYTE;
  localparam int unsigned   CW        = $clog2(BPW);
  localparam logic [CW-1:0] LAST_BYTE = CW'(BPW - 1);
  localparam logic [NB-1:0] LAST_ADDR = NB'((TAM_I - 1) * 4);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RECEIVE = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [NB-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [NB-1:0] addr_q,  addr_d;
  logic [NB-1:0] data_q,  data_d;
  logic [NB-1:0] wc_q,    wc_d;
  logic          ovf_q,   ovf_d;

  // Next-state logic: i_start restarts from any state and wins over a byte.
  // The write address is taken from the word count when the word completes,
  // which equals "previous address + 4" and keeps the address output stable
  // between writes.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wc_d    = wc_q;
    ovf_d   = ovf_q;
    if (i_start) begin
      state_d = ST_RECEIVE;
      cnt_d   = '0;
      addr_d  = '0;
      wc_d    = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_RECEIVE: begin
          if (i_rx_valid) begin
            shift_d = {shift_q[NB-NB_BYTE-1:0], i_rx_data};
            if (cnt_q == LAST_BYTE) begin
              data_d  = {shift_q[NB-NB_BYTE-1:0], i_rx_data};
              addr_d  = {wc_q[NB-3:0], 2'b00};
              cnt_d   = '0;
              state_d = ST_WRITE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        ST_WRITE: begin
          wc_d = wc_q + NB'(1);
          if (data_q == HALT_WORD) begin
            state_d = ST_DONE;
            ovf_d   = 1'b0;
          end else if (addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
            ovf_d   = 1'b1;
          end else begin
            state_d = ST_RECEIVE;
            if (i_rx_valid) begin
              shift_d = {shift_q[NB-NB_BYTE-1:0], i_rx_data};
              cnt_d   = CW'(1);
            end
          end
        end
        ST_IDLE, ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wc_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wc_q    <= wc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_instruction_write_enable = (state_q == ST_WRITE);
  assign o_instruction_address      = addr_q;
  assign o_instruction_data         = data_q;
  assign o_busy                     = (state_q == ST_RECEIVE) || (state_q == ST_WRITE);
  assign o_done                     = (state_q == ST_DONE);
  assign o_overflow                 = ovf_q;
  assign o_word_count               = wc_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed scenarios followed by
// random byte/start traffic, all compared against a queue-based load model.
module tb_instruction_loader;

  localparam int unsigned TAM = 4;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [31:0] wcount;

  int total = 0;
  int bad   = 0;

  // model of one load session
  bit          m_loading;
  bit          m_writing;
  bit          m_done;
  bit          m_ovf;
  int          m_words;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic [7:0]  m_bytes[$];

  instruction_loader #(.TAM_I(TAM)) dut (
    .i_clk                      (clk),
    .i_reset                    (rst_n),
    .i_start                    (i_start),
    .i_rx_data                  (i_rx_data),
    .i_rx_valid                 (i_rx_valid),
    .o_instruction_write_enable (we),
    .o_instruction_address      (addr),
    .o_instruction_data         (data),
    .o_busy                     (busy),
    .o_done                     (done),
    .o_overflow                 (ovf),
    .o_word_count               (wcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_loading = 0; m_writing = 0; m_done = 0; m_ovf = 0;
    m_words = 0; m_addr = '0; m_data = '0;
    m_bytes.delete();
  endtask

  task automatic model_step(input bit s, input bit v, input logic [7:0] d);
    bit was_writing;
    was_writing = m_writing;
    m_writing   = 0;
    if (s) begin
      m_loading = 1; m_done = 0; m_ovf = 0; m_words = 0; m_addr = '0;
      m_bytes.delete();
    end else if (was_writing) begin
      m_words++;
      if (m_data == HALT) begin
        m_loading = 0; m_done = 1; m_ovf = 0;
      end else if (m_words == TAM) begin
        m_loading = 0; m_done = 1; m_ovf = 1;
      end else if (v) begin
        m_bytes.push_back(d);
      end
    end else if (m_loading && v) begin
      m_bytes.push_back(d);
      if (m_bytes.size() == 4) begin
        m_data    = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
        m_addr    = 32'(m_words * 4);
        m_writing = 1;
        m_bytes.delete();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("we",     {31'd0, we},   {31'd0, m_writing});
    chk("addr",   addr,          m_addr);
    chk("data",   data,          m_data);
    chk("busy",   {31'd0, busy}, {31'd0, m_loading});
    chk("done",   {31'd0, done}, {31'd0, m_done});
    chk("ovf",    {31'd0, ovf},  {31'd0, m_ovf});
    chk("wcount", wcount,        32'(m_words));
  endtask

  task automatic step(input bit s, input bit v, input logic [7:0] d);
    i_start = s; i_rx_valid = v; i_rx_data = d;
    @(posedge clk);
    model_step(s, v, d);
    #1;
    i_start = 0; i_rx_valid = 0;
    check_all();
  endtask

  task automatic send_byte(input logic [7:0] d);
    step(0, 1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00);
  endtask

  initial begin
    i_start = 0; i_rx_valid = 0; i_rx_data = '0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1;
    idle(1);

    // basic load
    step(1, 0, 8'h00);
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    chk("basic_w1_we",   {31'd0, we}, 32'd1);
    chk("basic_w1_addr", addr, 32'd0);
    chk("basic_w1_data", data, 32'h20010005);
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    chk("basic_w2_addr", addr, 32'd4);
    chk("basic_w2_data", data, 32'hFFFFFFFF);
    idle(2);
    chk("basic_done", {31'd0, done}, 32'd1);
    chk("basic_ovf",  {31'd0, ovf},  32'd0);
    chk("basic_wc",   wcount, 32'd2);

    // overflow: memory of 4 words, no HALT
    step(1, 0, 8'h00);
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    chk("ovf_last_addr", addr, 32'd12);
    chk("ovf_last_data", data, 32'h0D0E0F10);
    idle(1);
    chk("ovf_done", {31'd0, done}, 32'd1);
    chk("ovf_flag", {31'd0, ovf},  32'd1);
    for (int i = 0; i < 4; i++) send_byte(8'h33);
    chk("ovf_wc", wcount, 32'd4);

    // restart mid-word, start wins over a simultaneous byte
    step(1, 0, 8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    step(1, 1, 8'h99);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    chk("restart_addr", addr, 32'd0);
    chk("restart_data", data, 32'h11223344);
    idle(1);
    chk("restart_wc", wcount, 32'd1);

    // back-to-back: byte of word 2 arrives in the write cycle of word 1
    step(1, 0, 8'h00);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    chk("b2b_addr", addr, 32'd4);
    chk("b2b_data", data, 32'h05060708);
    idle(1);

    // asynchronous reset between edges mid-receive
    send_byte(8'h55);
    rst_n = 0;
    #2;
    model_reset();
    check_all();
    #2 rst_n = 1;
    for (int i = 0; i < 8; i++) send_byte(8'hFF);

    // reload after done
    step(1, 0, 8'h00);
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    idle(1);
    step(1, 0, 8'h00);
    chk("reload_done_low", {31'd0, done}, 32'd0);
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    chk("reload_addr", addr, 32'd0);
    idle(1);
    chk("reload_wc",   wcount, 32'd1);
    chk("reload_done", {31'd0, done}, 32'd1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      bit          s;
      bit          v;
      logic [7:0]  d;
      s = ($urandom_range(0, 39) == 0);
      v = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 3) < 2) ? 8'hFF : 8'($urandom);
      step(s, v, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
